writeback_arbiter: RTL and testbench
====================================

// Module: writeback_arbiter
// PURPOSE
//  Parametrised writeback stage: collects results from NUM_SRC execution-unit channels
//  (result, dest creg, instr tag, write-enable) and drives NUM_WPORTS register-file write ports.
//  Per-source FIFOs absorb contention; a round-robin arbiter grants up to NUM_WPORTS heads per cycle.
//  Sits between the execute units and the regfile/commit logic; regfile ports never back-pressure.
// PARAMETERS
//  NUM_SRC     4   number of execution-unit result channels (>=1)
//  NUM_WPORTS  2   number of regfile write ports (1..NUM_SRC)
//  DATA_W      64  result width (word_t)
//  RADDR_W     6   destination creg address width (creg_addr_t)
//  TAG_W       5   instruction tag width (completion id)
//  FIFO_DEPTH  2   entries per source FIFO (>=1)
// PORTS
//  clk         in   1                    clock, all state on rising edge
//  resetn      in   1                    asynchronous, active-low reset
//  flush       in   1                    synchronous pipeline flush, discards all buffered results
//  src_valid   in   NUM_SRC              per-source result valid
//  src_ready   out  NUM_SRC              per-source FIFO can accept
//  src_we      in   NUM_SRC              entry writes a register (0 = completion only)
//  src_rd      in   NUM_SRC*RADDR_W      destination creg per source
//  src_result  in   NUM_SRC*DATA_W       result per source
//  src_tag     in   NUM_SRC*TAG_W        instruction tag per source
//  wb_valid    out  NUM_WPORTS           write port k carries an entry this cycle
//  wb_we       out  NUM_WPORTS           regfile write enable (= wb_valid & entry we)
//  wb_rd       out  NUM_WPORTS*RADDR_W   destination creg
//  wb_data     out  NUM_WPORTS*DATA_W    write data
//  wb_tag      out  NUM_WPORTS*TAG_W     tag for completion marking
// BEHAVIOUR
//  - Reset (resetn=0): FIFOs empty, rr pointer=0, all wb_* outputs 0, src_ready forced 0 while
//    resetn low; takes effect immediately, independent of clk.
//  - src_ready[i] = resetn & (count[i] < FIFO_DEPTH); depends on registered count only, never on
//    src_valid or the same-cycle dequeue. Enqueue when src_valid[i] & src_ready[i].
//  - Arbitration (combinational, per cycle): scan sources rr, rr+1, ... mod NUM_SRC; grant the
//    first up-to-NUM_WPORTS non-empty FIFOs; at most one entry per source per cycle. Grant j
//    (in scan order) goes to port j; ports above the grant count are idle.
//  - Granted heads are dequeued at the edge; wb_* are registered, so an entry handshaked in
//    cycle t appears on wb_* no earlier than cycle t+2. Ports are valid for exactly one cycle.
//  - rr update: if >=1 grant, rr <= (last granted source + 1) mod NUM_SRC; else unchanged.
//  - Per-source order preserved; no ordering guarantee across sources.
//  - wb_we=0 entries still consume a port (tag reported, no regfile write); wb_rd/wb_data still driven.
//  - Simultaneous enqueue/dequeue on one FIFO: both happen, count unchanged.
//  - Full FIFO dequeued this cycle: src_ready stays 0 this cycle, 1 next cycle.
//  - Pointers wrap mod FIFO_DEPTH; count width holds 0..FIFO_DEPTH inclusive.
//  - flush=1 at edge: all FIFOs emptied, rr<=0, wb_valid/wb_we<=0 next cycle; enqueues and grants
//    in the flush cycle are discarded (flush wins).
//  - Idle wb ports: wb_valid=wb_we=0; wb_rd/data/tag hold last value (don't care).
// TESTING
//  1 Single: src1 valid cycle 0, rd=5, data=0xDEAD, tag=3, we=1 -> cycle 2 wb_valid=01, port0
//    rd=5 data=0xDEAD tag=3 we=1; cycle 3 wb_valid=00; rr=2.
//  2 Contention: all 4 sources valid cycle 0 (tags 0..3) -> cycle 2 ports {src0,src1},
//    cycle 3 {src2,src3}, then idle; rr=0.
//  3 Fairness/backpressure: all 4 sources stream continuously 20 cycles -> each source granted
//    once per 2 cycles, src_ready drops when count=2, no tag lost/duplicated, per-source order kept.
//  4 Flush: 4 entries buffered, flush=1 with src0 valid same cycle -> next cycle wb_valid=00,
//    all src_ready=1, no buffered tag ever appears.
//  5 Async reset: resetn low mid-stream between edges -> wb_valid=00, src_ready=0000 at once;
//    after release no output until new src_valid; first grant starts at src0.
//  6 we=0 + config NUM_WPORTS=1: src2 we=0 tag=7 -> port0 wb_valid=1 wb_we=0 tag=7; with
//    NUM_WPORTS=1, 3 simultaneous sources drain one per cycle in rr order.

Source files
------------

// File: rtl/writeback_arbiter.sv
// ---------------------------------------------------------------------------
// writeback_arbiter
//
// Writeback stage that gathers results from NUM_SRC execution-unit channels
// and drives NUM_WPORTS register-file write ports. Each source has a small
// FIFO to absorb contention. A round-robin scan picks up to NUM_WPORTS
// non-empty FIFOs per cycle, and their heads are registered onto the write
// ports. The regfile never back-pressures, so a granted head always leaves
// its FIFO at the next edge.
//
// Ports
//   clk        : clock, all state updates on the rising edge
//   resetn     : asynchronous active-low reset
//   flush      : synchronous flush, discards every buffered result
//   src_valid  : per-source result valid
//   src_ready  : per-source FIFO has room (registered count only)
//   src_we     : per-source "entry writes a register" flag
//   src_rd     : per-source destination creg, packed NUM_SRC*RADDR_W
//   src_result : per-source result data, packed NUM_SRC*DATA_W
//   src_tag    : per-source instruction tag, packed NUM_SRC*TAG_W
//   wb_valid   : write port k carries an entry this cycle
//   wb_we      : regfile write enable (wb_valid & entry we)
//   wb_rd      : destination creg per port, packed NUM_WPORTS*RADDR_W
//   wb_data    : write data per port, packed NUM_WPORTS*DATA_W
//   wb_tag     : completion tag per port, packed NUM_WPORTS*TAG_W
// ---------------------------------------------------------------------------
module writeback_arbiter #(
  parameter int NUM_SRC    = 4,
  parameter int NUM_WPORTS = 2,
  parameter int DATA_W     = 64,
  parameter int RADDR_W    = 6,
  parameter int TAG_W      = 5,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          flush,
  input  logic [NUM_SRC-1:0]            src_valid,
  output logic [NUM_SRC-1:0]            src_ready,
  input  logic [NUM_SRC-1:0]            src_we,
  input  logic [NUM_SRC*RADDR_W-1:0]    src_rd,
  input  logic [NUM_SRC*DATA_W-1:0]     src_result,
  input  logic [NUM_SRC*TAG_W-1:0]      src_tag,
  output logic [NUM_WPORTS-1:0]         wb_valid,
  output logic [NUM_WPORTS-1:0]         wb_we,
  output logic [NUM_WPORTS*RADDR_W-1:0] wb_rd,
  output logic [NUM_WPORTS*DATA_W-1:0]  wb_data,
  output logic [NUM_WPORTS*TAG_W-1:0]   wb_tag
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [SRC_W-1:0] LAST_SRC = SRC_W'(NUM_SRC - 1);

  // FIFO storage, one row per source
  logic [DATA_W-1:0]  dataMem_q [NUM_SRC][FIFO_DEPTH];
  logic [RADDR_W-1:0] rdMem_q   [NUM_SRC][FIFO_DEPTH];
  logic [TAG_W-1:0]   tagMem_q  [NUM_SRC][FIFO_DEPTH];
  logic               weMem_q   [NUM_SRC][FIFO_DEPTH];

  logic [PTR_W-1:0] wrPtr_q [NUM_SRC];
  logic [PTR_W-1:0] wrPtr_d [NUM_SRC];
  logic [PTR_W-1:0] rdPtr_q [NUM_SRC];
  logic [PTR_W-1:0] rdPtr_d [NUM_SRC];
  logic [CNT_W-1:0] count_q [NUM_SRC];
  logic [CNT_W-1:0] count_d [NUM_SRC];

  logic [SRC_W-1:0] rr_q;
  logic [SRC_W-1:0] rr_d;

  logic [NUM_SRC-1:0] push;
  logic [NUM_SRC-1:0] grant;
  logic [SRC_W-1:0]   portSrc [NUM_WPORTS];
  logic [SRC_W-1:0]   lastSrc;
  int                 nGrant;
  int                 scanIdx;

  logic [NUM_WPORTS-1:0]         wbValid_q, wbValid_d;
  logic [NUM_WPORTS-1:0]         wbWe_q, wbWe_d;
  logic [NUM_WPORTS*RADDR_W-1:0] wbRd_q, wbRd_d;
  logic [NUM_WPORTS*DATA_W-1:0]  wbData_q, wbData_d;
  logic [NUM_WPORTS*TAG_W-1:0]   wbTag_q, wbTag_d;

  function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  // Ready looks only at the registered occupancy, so a full FIFO being
  // drained this cycle still reports not-ready until the next cycle. Holding
  // ready low during reset keeps producers from handshaking into a FIFO that
  // is being cleared.
  always_comb begin
    src_ready = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      src_ready[s] = resetn && (count_q[s] < DEPTH_C);
    end
  end

  assign push = src_valid & src_ready;

  // Round-robin scan starting at rr_q: the first NUM_WPORTS non-empty FIFOs
  // win, and grant j in scan order is steered to write port j. The pointer
  // then moves just past the last winner so that source goes to the back.
  always_comb begin
    grant   = '0;
    nGrant  = 0;
    scanIdx = 0;
    lastSrc = '0;
    for (int k = 0; k < NUM_WPORTS; k++) begin
      portSrc[k] = '0;
    end
    for (int k = 0; k < NUM_SRC; k++) begin
      scanIdx = int'(rr_q) + k;
      if (scanIdx >= NUM_SRC) begin
        scanIdx = scanIdx - NUM_SRC;
      end
      if ((count_q[scanIdx] != '0) && (nGrant < NUM_WPORTS)) begin
        grant[scanIdx]  = 1'b1;
        portSrc[nGrant] = SRC_W'(scanIdx);
        lastSrc         = SRC_W'(scanIdx);
        nGrant          = nGrant + 1;
      end
    end
    rr_d = rr_q;
    if (nGrant > 0) begin
      rr_d = (lastSrc == LAST_SRC) ? '0 : lastSrc + SRC_W'(1);
    end
  end

  // FIFO pointer and occupancy bookkeeping. A simultaneous push and pop
  // leaves the count unchanged.
  always_comb begin
    for (int s = 0; s < NUM_SRC; s++) begin
      wrPtr_d[s] = push[s]  ? nextPtr(wrPtr_q[s]) : wrPtr_q[s];
      rdPtr_d[s] = grant[s] ? nextPtr(rdPtr_q[s]) : rdPtr_q[s];
      count_d[s] = count_q[s];
      if (push[s] && !grant[s]) begin
        count_d[s] = count_q[s] + CNT_W'(1);
      end else if (!push[s] && grant[s]) begin
        count_d[s] = count_q[s] - CNT_W'(1);
      end
    end
  end

  // Next write-port contents. Idle ports drop valid/we but keep their
  // payload fields, which saves toggling on the wide data bus.
  always_comb begin
    wbValid_d = '0;
    wbWe_d    = '0;
    wbRd_d    = wbRd_q;
    wbData_d  = wbData_q;
    wbTag_d   = wbTag_q;
    for (int k = 0; k < NUM_WPORTS; k++) begin
      if (k < nGrant) begin
        wbValid_d[k]                     = 1'b1;
        wbWe_d[k]                        = weMem_q[portSrc[k]][rdPtr_q[portSrc[k]]];
        wbRd_d[k*RADDR_W +: RADDR_W]     = rdMem_q[portSrc[k]][rdPtr_q[portSrc[k]]];
        wbData_d[k*DATA_W +: DATA_W]     = dataMem_q[portSrc[k]][rdPtr_q[portSrc[k]]];
        wbTag_d[k*TAG_W +: TAG_W]        = tagMem_q[portSrc[k]][rdPtr_q[portSrc[k]]];
      end
    end
  end

  // FIFO payload storage. It has no reset because the pointers and counts
  // alone decide which slots are live; stale writes during a flush are
  // harmless for the same reason.
  always_ff @(posedge clk) begin
    for (int s = 0; s < NUM_SRC; s++) begin
      if (push[s]) begin
        dataMem_q[s][wrPtr_q[s]] <= src_result[s*DATA_W +: DATA_W];
        rdMem_q[s][wrPtr_q[s]]   <= src_rd[s*RADDR_W +: RADDR_W];
        tagMem_q[s][wrPtr_q[s]]  <= src_tag[s*TAG_W +: TAG_W];
        weMem_q[s][wrPtr_q[s]]   <= src_we[s];
      end
    end
  end

  // FIFO control and round-robin pointer. Flush takes priority over any
  // enqueue or grant in the same cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rr_q <= '0;
      for (int s = 0; s < NUM_SRC; s++) begin
        wrPtr_q[s] <= '0;
        rdPtr_q[s] <= '0;
        count_q[s] <= '0;
      end
    end else if (flush) begin
      rr_q <= '0;
      for (int s = 0; s < NUM_SRC; s++) begin
        wrPtr_q[s] <= '0;
        rdPtr_q[s] <= '0;
        count_q[s] <= '0;
      end
    end else begin
      rr_q <= rr_d;
      for (int s = 0; s < NUM_SRC; s++) begin
        wrPtr_q[s] <= wrPtr_d[s];
        rdPtr_q[s] <= rdPtr_d[s];
        count_q[s] <= count_d[s];
      end
    end
  end

  // Registered write ports, so each port is valid for exactly one cycle per
  // granted entry. Flush kills the grants of its own cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wbValid_q <= '0;
      wbWe_q    <= '0;
      wbRd_q    <= '0;
      wbData_q  <= '0;
      wbTag_q   <= '0;
    end else if (flush) begin
      wbValid_q <= '0;
      wbWe_q    <= '0;
    end else begin
      wbValid_q <= wbValid_d;
      wbWe_q    <= wbWe_d;
      wbRd_q    <= wbRd_d;
      wbData_q  <= wbData_d;
      wbTag_q   <= wbTag_d;
    end
  end

  assign wb_valid = wbValid_q;
  assign wb_we    = wbWe_q;
  assign wb_rd    = wbRd_q;
  assign wb_data  = wbData_q;
  assign wb_tag   = wbTag_q;

endmodule

// File: tb/tb_writeback_arbiter.sv
// ---------------------------------------------------------------------------
// tb_writeback_arbiter
//
// Directed bench for writeback_arbiter. The main instance uses the default
// 4-source / 2-port configuration. A second instance with a single write port
// checks one-per-cycle draining in round-robin order.
// ---------------------------------------------------------------------------
module tb_writeback_arbiter;

  localparam int NS = 4;
  localparam int NW = 2;
  localparam int DW = 64;
  localparam int RW = 6;
  localparam int TW = 5;
  localparam int FD = 2;

  logic clk = 1'b0;
  logic resetn;
  logic flush;

  logic [NS-1:0]    srcValid, srcReady, srcWe;
  logic [NS*RW-1:0] srcRd;
  logic [NS*DW-1:0] srcResult;
  logic [NS*TW-1:0] srcTag;
  logic [NW-1:0]    wbValid, wbWe;
  logic [NW*RW-1:0] wbRd;
  logic [NW*DW-1:0] wbData;
  logic [NW*TW-1:0] wbTag;

  logic [NS-1:0]    s1Valid, s1Ready, s1We;
  logic [NS*RW-1:0] s1Rd;
  logic [NS*DW-1:0] s1Result;
  logic [NS*TW-1:0] s1Tag;
  logic [0:0]       w1Valid, w1We;
  logic [RW-1:0]    w1Rd;
  logic [DW-1:0]    w1Data;
  logic [TW-1:0]    w1Tag;

  int errCount   = 0;
  int checkCount = 0;
  int inSeq  [NS];
  int outSeq [NS];

  writeback_arbiter #(
    .NUM_SRC(NS), .NUM_WPORTS(NW), .DATA_W(DW),
    .RADDR_W(RW), .TAG_W(TW), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .src_valid(srcValid), .src_ready(srcReady), .src_we(srcWe),
    .src_rd(srcRd), .src_result(srcResult), .src_tag(srcTag),
    .wb_valid(wbValid), .wb_we(wbWe), .wb_rd(wbRd),
    .wb_data(wbData), .wb_tag(wbTag)
  );

  writeback_arbiter #(
    .NUM_SRC(NS), .NUM_WPORTS(1), .DATA_W(DW),
    .RADDR_W(RW), .TAG_W(TW), .FIFO_DEPTH(FD)
  ) dutOnePort (
    .clk(clk), .resetn(resetn), .flush(flush),
    .src_valid(s1Valid), .src_ready(s1Ready), .src_we(s1We),
    .src_rd(s1Rd), .src_result(s1Result), .src_tag(s1Tag),
    .wb_valid(w1Valid), .wb_we(w1We), .wb_rd(w1Rd),
    .wb_data(w1Data), .wb_tag(w1Tag)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  // Every comparison goes through here.
  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Drive one source channel of the main instance.
  task automatic applyStimulus(input int s, input logic v, input logic we,
                               input logic [RW-1:0] rd, input logic [DW-1:0] data,
                               input logic [TW-1:0] tg);
    srcValid[s]          = v;
    srcWe[s]             = we;
    srcRd[s*RW +: RW]    = rd;
    srcResult[s*DW +: DW] = data;
    srcTag[s*TW +: TW]   = tg;
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [TW-1:0] portTag(input int k);
    return wbTag[k*TW +: TW];
  endfunction

  function automatic logic [RW-1:0] portRd(input int k);
    return wbRd[k*RW +: RW];
  endfunction

  function automatic logic [DW-1:0] portData(input int k);
    return wbData[k*DW +: DW];
  endfunction

  // Per-source order tracking for the streaming test. Tags carry
  // {source[1:0], sequence[2:0]}.
  task automatic scoreOutputs();
    logic [TW-1:0] tg;
    int src;
    for (int k = 0; k < NW; k++) begin
      if (wbValid[k]) begin
        tg  = portTag(k);
        src = int'(tg >> 3);
        checkOutput("stream order", 64'(tg & 5'd7), 64'(outSeq[src] & 7));
        outSeq[src]++;
      end
    end
  endtask

  initial begin
    logic [TW-1:0] tg;
    logic [NS-1:0] accepted;

    resetn   = 1'b0;
    flush    = 1'b0;
    srcValid = '0; srcWe = '0; srcRd = '0; srcResult = '0; srcTag = '0;
    s1Valid  = '0; s1We  = '0; s1Rd  = '0; s1Result  = '0; s1Tag  = '0;
    for (int s = 0; s < NS; s++) begin
      inSeq[s]  = 0;
      outSeq[s] = 0;
    end

    // Reset state
    #12;
    checkOutput("reset wb_valid", 64'(wbValid), 64'h0);
    checkOutput("reset src_ready", 64'(srcReady), 64'h0);
    checkOutput("reset wb_data", 64'(wbData[DW-1:0]), 64'h0);
    resetn = 1'b1;
    step();
    checkOutput("post-reset src_ready", 64'(srcReady), 64'hF);

    // Test 1: single entry from src1
    applyStimulus(1, 1'b1, 1'b1, 6'd5, 64'hDEAD, 5'd3);
    step();
    srcValid = '0;
    checkOutput("single cycle1 wb_valid", 64'(wbValid), 64'h0);
    step();
    checkOutput("single wb_valid", 64'(wbValid), 64'h1);
    checkOutput("single wb_we", 64'(wbWe), 64'h1);
    checkOutput("single rd", 64'(portRd(0)), 64'd5);
    checkOutput("single data", portData(0), 64'hDEAD);
    checkOutput("single tag", 64'(portTag(0)), 64'd3);
    step();
    checkOutput("single cycle3 wb_valid", 64'(wbValid), 64'h0);

    // rr is now 2, so src2 outranks src0
    applyStimulus(0, 1'b1, 1'b1, 6'd1, 64'h10, 5'd10);
    applyStimulus(2, 1'b1, 1'b1, 6'd2, 64'h12, 5'd12);
    step();
    srcValid = '0;
    step();
    checkOutput("rr after single wb_valid", 64'(wbValid), 64'h3);
    checkOutput("rr after single port0", 64'(portTag(0)), 64'd12);
    checkOutput("rr after single port1", 64'(portTag(1)), 64'd10);
    step();

    // Flush to bring rr back to 0
    flush = 1'b1;
    step();
    flush = 1'b0;
    checkOutput("flush idle wb_valid", 64'(wbValid), 64'h0);

    // Test 2: all four sources in the same cycle
    for (int s = 0; s < NS; s++) begin
      applyStimulus(s, 1'b1, 1'b1, RW'(10 + s), DW'(100 + s), TW'(s));
    end
    step();
    srcValid = '0;
    step();
    checkOutput("contend c2 wb_valid", 64'(wbValid), 64'h3);
    checkOutput("contend c2 port0", 64'(portTag(0)), 64'd0);
    checkOutput("contend c2 port1", 64'(portTag(1)), 64'd1);
    checkOutput("contend c2 data1", portData(1), 64'd101);
    step();
    checkOutput("contend c3 wb_valid", 64'(wbValid), 64'h3);
    checkOutput("contend c3 port0", 64'(portTag(0)), 64'd2);
    checkOutput("contend c3 port1", 64'(portTag(1)), 64'd3);
    step();
    checkOutput("contend c4 wb_valid", 64'(wbValid), 64'h0);

    // Test 3: continuous streaming from all sources for 20 cycles
    for (int c = 0; c < 20; c++) begin
      for (int s = 0; s < NS; s++) begin
        tg = TW'((s << 3) | (inSeq[s] & 7));
        applyStimulus(s, 1'b1, 1'b1, RW'(s), DW'(s * 256 + inSeq[s]), tg);
      end
      if (c < 2) begin
        checkOutput("stream ready", 64'(srcReady), 64'hF);
        checkOutput("stream wb_valid", 64'(wbValid), 64'h0);
      end else begin
        checkOutput("stream ready", 64'(srcReady), (c % 2 == 0) ? 64'h3 : 64'hC);
        checkOutput("stream wb_valid", 64'(wbValid), 64'h3);
        checkOutput("fair port0", 64'(portTag(0) >> 3), (c % 2 == 0) ? 64'd0 : 64'd2);
        checkOutput("fair port1", 64'(portTag(1) >> 3), (c % 2 == 0) ? 64'd1 : 64'd3);
      end
      scoreOutputs();
      accepted = srcValid & srcReady;
      step();
      for (int s = 0; s < NS; s++) begin
        if (accepted[s]) inSeq[s]++;
      end
    end
    srcValid = '0;
    for (int c = 0; c < 6; c++) begin
      scoreOutputs();
      step();
    end
    checkOutput("stream drained", 64'(wbValid), 64'h0);
    for (int s = 0; s < NS; s++) begin
      checkOutput("stream count", 64'(outSeq[s]), 64'(inSeq[s]));
    end

    // Test 4: flush with entries buffered and an enqueue in the flush cycle
    for (int s = 0; s < NS; s++) begin
      applyStimulus(s, 1'b1, 1'b1, RW'(s), DW'(s), TW'(20 + s));
    end
    step();
    srcValid = '0;
    applyStimulus(0, 1'b1, 1'b1, 6'd0, 64'h0, 5'd24);
    flush = 1'b1;
    step();
    flush    = 1'b0;
    srcValid = '0;
    checkOutput("flush wb_valid", 64'(wbValid), 64'h0);
    checkOutput("flush src_ready", 64'(srcReady), 64'hF);
    for (int c = 0; c < 4; c++) begin
      checkOutput("flush stays idle", 64'(wbValid), 64'h0);
      step();
    end

    // Test 5: asynchronous reset in the middle of a stream
    for (int s = 0; s < NS; s++) begin
      applyStimulus(s, 1'b1, 1'b1, RW'(s), DW'(s), TW'(s));
    end
    step();
    step();
    checkOutput("pre-reset wb_valid", 64'(wbValid), 64'h3);
    #3;
    resetn = 1'b0;
    #1;
    checkOutput("async reset wb_valid", 64'(wbValid), 64'h0);
    checkOutput("async reset src_ready", 64'(srcReady), 64'h0);
    srcValid = '0;
    @(negedge clk);
    resetn = 1'b1;
    step();
    checkOutput("after reset wb_valid", 64'(wbValid), 64'h0);
    checkOutput("after reset src_ready", 64'(srcReady), 64'hF);
    step();
    checkOutput("after reset quiet", 64'(wbValid), 64'h0);
    applyStimulus(0, 1'b1, 1'b1, 6'd0, 64'h9, 5'd9);
    applyStimulus(2, 1'b1, 1'b1, 6'd2, 64'hB, 5'd11);
    step();
    srcValid = '0;
    step();
    checkOutput("reset rr wb_valid", 64'(wbValid), 64'h3);
    checkOutput("reset rr port0", 64'(portTag(0)), 64'd9);
    checkOutput("reset rr port1", 64'(portTag(1)), 64'd11);
    step();

    // Test 6: completion-only entry (we=0)
    applyStimulus(2, 1'b1, 1'b0, 6'd9, 64'h77, 5'd7);
    step();
    srcValid = '0;
    step();
    checkOutput("we0 wb_valid", 64'(wbValid), 64'h1);
    checkOutput("we0 wb_we", 64'(wbWe), 64'h0);
    checkOutput("we0 tag", 64'(portTag(0)), 64'd7);
    checkOutput("we0 rd", 64'(portRd(0)), 64'd9);
    checkOutput("we0 data", portData(0), 64'h77);
    step();

    // Single write port: three sources drain one per cycle in rr order
    for (int s = 1; s < NS; s++) begin
      s1Valid[s]           = 1'b1;
      s1We[s]              = 1'b1;
      s1Rd[s*RW +: RW]     = RW'(s);
      s1Result[s*DW +: DW] = DW'(s * 16);
      s1Tag[s*TW +: TW]    = TW'(s);
    end
    step();
    s1Valid = '0;
    checkOutput("1port c1 wb_valid", 64'(w1Valid), 64'h0);
    step();
    checkOutput("1port c2 wb_valid", 64'(w1Valid), 64'h1);
    checkOutput("1port c2 wb_we", 64'(w1We), 64'h1);
    checkOutput("1port c2 tag", 64'(w1Tag), 64'd1);
    step();
    checkOutput("1port c3 tag", 64'(w1Tag), 64'd2);
    checkOutput("1port c3 data", w1Data, 64'd32);
    step();
    checkOutput("1port c4 tag", 64'(w1Tag), 64'd3);
    checkOutput("1port c4 wb_valid", 64'(w1Valid), 64'h1);
    step();
    checkOutput("1port c5 wb_valid", 64'(w1Valid), 64'h0);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
